// File: rtl/interrupt_controller_pkg.sv
// Shared encodings and helpers for the interrupt controller: FSM states, ID width,
// and the fixed-priority (lowest index wins) encoder used for line selection.
package interrupt_controller_pkg;

    localparam int IC_NUM_IRQ = 4;
    localparam int IRQ_ID_W   = 2;

    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_ASSERT  = 2'd1,
        IC_SERVICE = 2'd2
    } ic_state_e;

    // Scan from the top down so the lowest set index is the last one written.
    function automatic logic [IRQ_ID_W-1:0] irq_prio_enc(input logic [IC_NUM_IRQ-1:0] req);
        logic [IRQ_ID_W-1:0] id;
        id = '0;
        for (int i = IC_NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = IRQ_ID_W'(i);
            end
        end
        return id;
    endfunction

    function automatic logic [IC_NUM_IRQ-1:0] irq_onehot(input logic [IRQ_ID_W-1:0] id);
        return IC_NUM_IRQ'(1) << id;
    endfunction

endpackage

// File: rtl/interrupt_controller_sync_edge.sv
// Per-line synchroniser plus previous-value flop; edge_pulse is high for one cycle on a
// synchronised 0->1 transition, SYNC_STAGES cycles after the line is first sampled high.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_async,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_async};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Latches synchronised irq edges as pending, masks them, and raises one registered NMI pulse
// per request; further requests wait until int_done ends the current service.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_IRQ     = IC_NUM_IRQ,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                mask_we,
    input  logic [NUM_IRQ-1:0]  mask_wdata,
    input  logic                int_done,
    output logic                NMI,
    output logic [IRQ_ID_W-1:0] NMI_ID,
    output logic [NUM_IRQ-1:0]  pending,
    output logic [NUM_IRQ-1:0]  mask,
    output logic                in_service
);

    logic [NUM_IRQ-1:0]  edges;
    logic [NUM_IRQ-1:0]  pending_q, pending_d;
    logic [NUM_IRQ-1:0]  mask_q, mask_d;
    logic [NUM_IRQ-1:0]  req;
    logic [NUM_IRQ-1:0]  clr;
    logic [IRQ_ID_W-1:0] winner;
    logic                take;

    ic_state_e           state_q, state_d;
    logic                nmi_q, nmi_d;
    logic [IRQ_ID_W-1:0] nmi_id_q, nmi_id_d;
    logic                in_service_q, in_service_d;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk       (clk),
            .reset     (reset),
            .irq_async (irq_in[i]),
            .edge_pulse(edges[i])
        );
    end

    // Selection always sees the registered mask, so a same-cycle mask write takes effect next cycle.
    always_comb begin
        req    = pending_q & ~mask_q;
        winner = irq_prio_enc(req);
        take   = (state_q == IC_IDLE) && (req != '0);
        clr    = take ? irq_onehot(winner) : '0;
    end

    // Set after clear: a fresh edge on the line being granted keeps its pending bit.
    always_comb begin
        pending_d = (pending_q & ~clr) | edges;
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            mask_q    <= '1;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IC_IDLE:    if (req != '0) state_d = IC_ASSERT;
            IC_ASSERT:  state_d = IC_SERVICE;
            IC_SERVICE: if (int_done) state_d = IC_IDLE;
            default:    state_d = IC_IDLE;
        endcase
    end

    always_comb begin
        nmi_d        = take;
        nmi_id_d     = take ? winner : nmi_id_q;
        in_service_d = in_service_q;
        case (state_q)
            IC_ASSERT:  in_service_d = 1'b1;
            IC_SERVICE: if (int_done) in_service_d = 1'b0;
            default:    in_service_d = in_service_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nmi_q        <= 1'b0;
            nmi_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            nmi_q        <= nmi_d;
            nmi_id_q     <= nmi_id_d;
            in_service_q <= in_service_d;
        end
    end

    assign NMI        = nmi_q;
    assign NMI_ID     = nmi_id_q;
    assign pending    = pending_q;
    assign mask       = mask_q;
    assign in_service = in_service_q;

endmodule
